regdst_mux_pipe: RTL
====================

REGDST_MUX_PIPE -- requirements
Module: regdst_mux_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data width of each entry and of out.
REQ-002 SHALL have parameter N_ENTRIES, default 5, number of selectable entries (range 2..16).
REQ-003 SHALL have parameter SEL_W, default 3, width of controlSignal; SEL_W >= clog2(N_ENTRIES).
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port entries  input  N_ENTRIES*WIDTH  packed entries; entry k at bits [k*WIDTH +: WIDTH].
REQ-007 SHALL have port controlSignal  input  SEL_W  entry index for direct mode.
REQ-008 SHALL have port mode  input  1  0 = direct, 1 = scan; sampled only on accepted request.
REQ-009 SHALL have port in_valid  input  1  request present.
REQ-010 SHALL have port in_ready  output  1  request accepted when in_valid && in_ready.
REQ-011 SHALL have port out  output  WIDTH  registered selected data.
REQ-012 SHALL have port out_valid  output  1  out holds an unconsumed result.
REQ-013 SHALL have port out_ready  input  1  consumer takes out when out_valid && out_ready.
REQ-014 SHALL have port out_idx  output  SEL_W  index of entry currently on out.
REQ-015 SHALL have port sel_err  output  1  current out came from an out-of-range select.

Function
REQ-016 SHALL implement FSM states IDLE and SCAN plus a one-deep output register (out, out_valid, out_idx, sel_err).
REQ-017 In IDLE, in_ready SHALL equal !out_valid || out_ready; in SCAN, in_ready SHALL be 0.
REQ-018 Direct accept (mode=0) SHALL load out with entry[controlSignal], out_idx=controlSignal, out_valid=1 on the next edge; latency 1 cycle.
REQ-019 Scan accept (mode=1) SHALL snapshot all entries, load out=entry0, out_idx=0, out_valid=1, and move IDLE->SCAN.
REQ-020 In SCAN, each out handshake SHALL load the next snapshot entry (idx+1) the same edge; no bubble under continuous out_ready.
REQ-021 On the handshake of index N_ENTRIES-1 in SCAN, the FSM SHALL return to IDLE, index counter wrapping to 0, out_valid dropping unless a new request is accepted that edge (not possible in SCAN, so out_valid=0).
REQ-022 Changes to entries during SCAN SHALL NOT affect emitted data.
REQ-023 While out_valid && !out_ready, out, out_idx, sel_err SHALL hold stable.
REQ-024 IDLE handshake on out simultaneous with a new accept SHALL replace out with the new result (back-to-back throughput 1/cycle).
REQ-025 out_idx SHALL be SEL_W wide; scan counter arithmetic SHALL be SEL_W bits, never exceeding N_ENTRIES-1.

Reset
REQ-026 reset SHALL take priority over all other inputs, including mid-SCAN.
REQ-027 After reset: state=IDLE, out=0, out_valid=0, out_idx=0, sel_err=0, scan counter=0, in_ready=1.

Configuration
REQ-028 Macro REGDSTMUX_SELERR_EN: when defined, a direct select >= N_ENTRIES SHALL produce out=0 and sel_err=1 for that result.
REQ-029 Without REGDSTMUX_SELERR_EN, sel_err SHALL be tied 0 and an out-of-range select SHALL produce entry 0 with out_idx=0.

Verification (N_ENTRIES=5, WIDTH=32, entries 0..4 = 0x0000FFFF, 0x000001FF, 0x0000001F, 0x00000001, 0x00000000)
REQ-030 Reset then direct selects 0,1,2,3,4, out_ready=1 -> out 0x0000FFFF,0x000001FF,0x0000001F,0x00000001,0x00000000 one cycle after each accept, out_idx matching.
REQ-031 Direct select 2, out_ready=0 for 3 cycles -> out=0x0000001F held, in_ready=0, then consumed on first out_ready=1 cycle.
REQ-032 Scan request, out_ready=1, entry1 changed to 0xDEADBEEF after accept -> 5 results in 5 consecutive cycles, second = 0x000001FF, in_ready=0 throughout, IDLE afterwards.
REQ-033 Direct select 6 -> with REGDSTMUX_SELERR_EN out=0, sel_err=1; without it out=0x0000FFFF, out_idx=0, sel_err=0.
REQ-034 Scan request, reset asserted after third result -> next cycle out=0, out_valid=0, in_ready=1, state IDLE.

Source files
------------

// File: rtl/regdst_mux_pipe_if.sv
// Request/result bus of regdst_mux_pipe: packed entries, select, mode and the
// in/out valid-ready handshakes together with the registered result fields.
interface regdst_mux_pipe_if #(
   parameter int unsigned WIDTH     = 32,
   parameter int unsigned N_ENTRIES = 5,
   parameter int unsigned SEL_W     = 3
);
   logic [N_ENTRIES*WIDTH-1:0] entries;
   logic [SEL_W-1:0]           controlSignal;
   logic                       mode;
   logic                       in_valid;
   logic                       in_ready;
   logic [WIDTH-1:0]           out;
   logic                       out_valid;
   logic                       out_ready;
   logic [SEL_W-1:0]           out_idx;
   logic                       sel_err;

   modport master (
      output entries, controlSignal, mode, in_valid, out_ready,
      input  in_ready, out, out_valid, out_idx, sel_err
   );

   modport slave (
      input  entries, controlSignal, mode, in_valid, out_ready,
      output in_ready, out, out_valid, out_idx, sel_err
   );
endinterface

// File: rtl/regdst_mux_pipe.sv
// Entry selector with a one-deep registered output: direct select or a snapshot
// scan of all entries. Optional macro REGDSTMUX_SELERR_EN flags out-of-range selects.
module regdst_mux_pipe #(
   parameter int unsigned WIDTH     = 32,
   parameter int unsigned N_ENTRIES = 5,
   parameter int unsigned SEL_W     = 3
) (
   input logic              clk,
   input logic              reset,
   regdst_mux_pipe_if.slave bus
);

   typedef enum logic {IDLE, SCAN} state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] snap_q [N_ENTRIES];
   logic [WIDTH-1:0] out_q, out_d;
   logic             out_valid_q, out_valid_d;
   logic [SEL_W-1:0] out_idx_q, out_idx_d;
   logic [SEL_W-1:0] cnt_q, cnt_d;
   logic             sel_err_q, sel_err_d;

   logic             in_ready_c;
   logic             accept_c;
   logic             out_hs_c;
   logic             scan_load_c;
   logic             dir_hit_c;
   logic [WIDTH-1:0] dir_data_c;
   logic [SEL_W-1:0] cnt_nxt_c;
   logic [WIDTH-1:0] scan_data_c;
   logic             scan_last_c;

   assign in_ready_c  = (state_q == IDLE) && (!out_valid_q || bus.out_ready);
   assign accept_c    = bus.in_valid && in_ready_c;
   assign out_hs_c    = out_valid_q && bus.out_ready;
   assign scan_load_c = accept_c && bus.mode;
   assign cnt_nxt_c   = SEL_W'(cnt_q + SEL_W'(1));
   assign scan_last_c = (cnt_q == SEL_W'(N_ENTRIES - 1));

   // Direct-mode mux; dir_hit_c is low for selects beyond the last entry.
   always_comb begin
      dir_hit_c  = 1'b0;
      dir_data_c = bus.entries[WIDTH-1:0];
      for (int unsigned k = 0; k < N_ENTRIES; k++) begin
         if (bus.controlSignal == SEL_W'(k)) begin
            dir_hit_c  = 1'b1;
            dir_data_c = bus.entries[k*WIDTH +: WIDTH];
         end
      end
   end

   always_comb begin
      scan_data_c = snap_q[0];
      for (int unsigned k = 0; k < N_ENTRIES; k++) begin
         if (cnt_nxt_c == SEL_W'(k)) scan_data_c = snap_q[k];
      end
   end

   always_comb begin
      state_d     = state_q;
      out_d       = out_q;
      out_valid_d = out_valid_q;
      out_idx_d   = out_idx_q;
      cnt_d       = cnt_q;
      sel_err_d   = sel_err_q;
      case (state_q)
         IDLE: begin
            if (accept_c) begin
               out_valid_d = 1'b1;
               sel_err_d   = 1'b0;
               if (bus.mode) begin
                  out_d     = bus.entries[WIDTH-1:0];
                  out_idx_d = '0;
                  cnt_d     = '0;
                  state_d   = SCAN;
               end else if (dir_hit_c) begin
                  out_d     = dir_data_c;
                  out_idx_d = bus.controlSignal;
               end else begin
`ifdef REGDSTMUX_SELERR_EN
                  out_d     = '0;
                  out_idx_d = bus.controlSignal;
                  sel_err_d = 1'b1;
`else
                  out_d     = bus.entries[WIDTH-1:0];
                  out_idx_d = '0;
`endif
               end
            end else if (out_hs_c) begin
               out_valid_d = 1'b0;
            end
         end
         SCAN: begin
            // Each consumed result is replaced by the next snapshot entry.
            if (out_hs_c) begin
               if (scan_last_c) begin
                  state_d     = IDLE;
                  cnt_d       = '0;
                  out_valid_d = 1'b0;
               end else begin
                  cnt_d     = cnt_nxt_c;
                  out_d     = scan_data_c;
                  out_idx_d = cnt_nxt_c;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         out_q       <= '0;
         out_valid_q <= 1'b0;
         out_idx_q   <= '0;
         cnt_q       <= '0;
         sel_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         out_q       <= out_d;
         out_valid_q <= out_valid_d;
         out_idx_q   <= out_idx_d;
         cnt_q       <= cnt_d;
         sel_err_q   <= sel_err_d;
      end
   end

   // Snapshot keeps scan output immune to entry changes while scanning.
   always_ff @(posedge clk) begin
      if (scan_load_c) begin
         for (int unsigned k = 0; k < N_ENTRIES; k++) begin
            snap_q[k] <= bus.entries[k*WIDTH +: WIDTH];
         end
      end
   end

   assign bus.in_ready  = in_ready_c;
   assign bus.out       = out_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_idx   = out_idx_q;
   assign bus.sel_err   = sel_err_q;

endmodule
